// File: rtl/mp_cache_data_arb.sv
// Two-port arbiter and sequencer for the cache's single-port data SRAM (port 0 = CPU hit path, port 1 = fill/writeback).
// Define MP_CACHE_ARB_RR_EN for round-robin arbitration; default build is fixed priority with port 1 favoured.
module mp_cache_data_arb #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_WMASKS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [NUM_WMASKS-1:0] req0_wmask,
    input  logic [DATA_WIDTH-1:0] req0_wdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [NUM_WMASKS-1:0] req1_wmask,
    input  logic [DATA_WIDTH-1:0] req1_wdata,

    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_rdata,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_rdata,

    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [NUM_WMASKS-1:0] sram_wmask,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    logic                  grant0;
    logic                  grant1;
    logic                  rd_grant;
    logic                  rd_pend;
    logic                  rd_owner;
    logic [DATA_WIDTH-1:0] hold0;
    logic [DATA_WIDTH-1:0] hold1;

`ifdef MP_CACHE_ARB_RR_EN
    logic prio;

    // Grants are masked while in reset so nothing reaches the SRAM until release.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            if (req0_valid && req1_valid) begin
                grant0 = ~prio;
                grant1 = prio;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (grant0) begin
            prio <= 1'b1;
        end else if (grant1) begin
            prio <= 1'b0;
        end
    end
`else
    // The fill/writeback engine always wins; the CPU port waits for a free slot.
    always_comb begin
        grant1 = rst_n && req1_valid;
        grant0 = rst_n && req0_valid && !req1_valid;
    end
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_din   = '0;
        if (grant1) begin
            sram_csb   = 1'b0;
            sram_web   = ~req1_we;
            sram_addr  = req1_addr;
            sram_wmask = req1_wmask;
            sram_din   = req1_wdata;
        end else if (grant0) begin
            sram_csb   = 1'b0;
            sram_web   = ~req0_we;
            sram_addr  = req0_addr;
            sram_wmask = req0_wmask;
            sram_din   = req0_wdata;
        end
    end

    assign rd_grant = (grant0 && !req0_we) || (grant1 && !req1_we);

    // rd_owner keeps its last value between reads; only rd_pend qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_pend <= rd_grant;
            if (rd_grant) begin
                rd_owner <= grant1;
            end
        end
    end

    assign resp0_valid = rd_pend && !rd_owner;
    assign resp1_valid = rd_pend && rd_owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            if (resp0_valid) begin
                hold0 <= sram_dout;
            end
            if (resp1_valid) begin
                hold1 <= sram_dout;
            end
        end
    end

    // Read data is passed straight through in the valid cycle, then held per port.
    assign resp0_rdata = resp0_valid ? sram_dout : hold0;
    assign resp1_rdata = resp1_valid ? sram_dout : hold1;

endmodule
